mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, single-slave memory arbiter that shares the core's one memory port between instruction fetch (read-only) and load/store (read/write). It sits between ifu/lsu and the memory/bus bridge, with one transaction outstanding at a time. Requests are latched, forwarded with valid/ready, and the response is routed back to the granted master. Simultaneous requests are resolved round-robin so that neither fetch nor data access starves.

## Interface
- DATA_LEN, 32, data width; a multiple of 8.
- ADDR_LEN, 32, address width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ifu_req_valid / ifu_req_ready  in / out  1  fetch request handshake.
- ifu_addr  in  ADDR_LEN  fetch address.
- ifu_rsp_valid / ifu_rsp_ready  out / in  1  fetch response handshake.
- ifu_rdata  out  DATA_LEN  fetched word.
- ifu_rsp_err  out  1  access fault for the fetch.
- lsu_req_valid / lsu_req_ready  in / out  1  data request handshake.
- lsu_addr  in  ADDR_LEN  data address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_LEN  store data.
- lsu_wstrb  in  DATA_LEN/8  byte strobes.
- lsu_rsp_valid / lsu_rsp_ready  out / in  1  data response handshake.
- lsu_rdata  out  DATA_LEN  load data.
- lsu_rsp_err  out  1  access fault for the data access.
- mem_req_valid / mem_req_ready  out / in  1  downstream request handshake.
- mem_addr, mem_wen, mem_wdata, mem_wstrb  out  ADDR_LEN, 1, DATA_LEN, DATA_LEN/8  latched request fields.
- mem_rsp_valid / mem_rsp_ready  in / out  1  downstream response handshake.
- mem_rdata  in  DATA_LEN  response data.
- mem_rsp_err  in  1  response fault.
- busy  out  1  high when state ≠ IDLE.
- grant_id  out  1  owner of the current transaction: 0 = ifu, 1 = lsu.

## Operation
- FSM states: IDLE, REQ, RSP. Reset state is IDLE.
- **IDLE:**
  - If exactly one master has req_valid, it wins.
  - If both do, the master other than last_grant wins.
  - The winner's req_ready is high combinationally; no other req_ready is ever high.
  - On the handshake: latch addr, wen, wdata and wstrb, set grant_id and last_grant to the winner, and go to REQ.
  - An ifu grant latches wen=0, wstrb=0, wdata=0.
- **REQ:** mem_req_valid=1 with the latched fields, held stable until mem_req_ready. Then go to RSP.
- **RSP:**
  - mem_rsp_ready = granted master's rsp_ready.
  - Granted master's rsp_valid = mem_rsp_valid; its rdata/err = mem_rdata/mem_rsp_err, passed through combinationally.
  - On the handshake, go to IDLE.
  - Store responses also pass mem_rdata through; the lsu ignores it.
- The non-granted master's rsp_valid is 0 in every state.
- mem_req_valid is 0 in IDLE and RSP; mem_rsp_ready is 0 in IDLE and REQ.
- A master may deassert req_valid before being granted; this causes no grant and no state change.
- mem_rsp_valid arriving outside RSP is protocol-illegal. It is ignored and never forwarded.

## Timing
- Reset values:
  - state=IDLE, last_grant=0 (ifu), so lsu wins the first contention.
  - grant_id=0, busy=0.
  - All latched fields 0, so mem_addr/mem_wdata/mem_wstrb/mem_wen = 0.
  - All valid/ready outputs 0.
- Minimum transaction: request accepted in cycle N (IDLE); mem_req_valid high in N+1; with mem_req_ready=1, RSP in N+2; with mem_rsp_valid=1 and master ready, the response completes in N+2.
- Next grant is no earlier than N+3, so at least 3 cycles per transaction. No zero-cycle back-to-back grant.
- The response path adds zero latency. The request path adds one register stage.
- Downstream stalls (ready/valid held low) hold the state indefinitely with all fields stable.
- Reset asserted mid-transaction returns to IDLE immediately. The in-flight response is dropped, and downstream must also be reset.

## Structure
- Shared package holds:
  - state encoding localparams IDLE=2'd0, REQ=2'd1, RSP=2'd2;
  - master ID constants ID_IFU=1'b0, ID_LSU=1'b1.
- One sub-module is natural: rr_arb2. It is the combinational two-way round-robin pick from (req0, req1, last_grant) to (gnt0, gnt1).
- The FSM, request latches and response mux stay in mem_arbiter.

## Test plan
- **Single fetch:** ifu_req_valid with addr 0x8000_0000; mem_req_ready=1, mem_rdata=0x0000_0413 → mem_addr=0x8000_0000, mem_wen=0, ifu_rdata=0x0000_0413, lsu_rsp_valid stays 0.
- **Store:** lsu addr 0x8000_1004, wdata 0xDEAD_BEEF, wstrb 4'b0011, wen=1 → the same values appear on mem_* one cycle after acceptance and stay stable across 5 cycles of mem_req_ready=0.
- **Contention from reset:** both requests valid in cycle 0 → lsu granted first. With both still valid after completion, ifu is granted next and then lsu again (alternation over 4 transactions).
- **Response backpressure:** ifu_rsp_ready=0 for 3 cycles while mem_rsp_valid=1 → mem_rsp_ready=0, state stays RSP, completion in the cycle ifu_rsp_ready rises.
- **Error:** mem_rsp_err=1 on an lsu load to 0x0000_0000 → lsu_rsp_err=1, ifu_rsp_err=0, then back to IDLE with busy=0.
- **Reset mid-transaction:** rst_n low in REQ → next sample shows busy=0, mem_req_valid=0, mem_addr=0. The first grant after release goes to lsu on contention.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-master memory arbiter: FSM state encoding and master IDs.
package mem_arbiter_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;

    localparam logic ID_IFU = 1'b0;
    localparam logic ID_LSU = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on contention the master that did not win last time is chosen.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = req0 & (~req1 | (last_grant == ID_LSU));
    assign gnt1 = req1 & (~req0 | (last_grant == ID_IFU));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight,
// with the request registered once and the response routed back combinationally.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_LEN-1:0]   ifu_addr,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [DATA_LEN-1:0]   ifu_rdata,
    output logic                  ifu_rsp_err,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_LEN-1:0]   lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_LEN-1:0]   lsu_wdata,
    input  logic [DATA_LEN/8-1:0] lsu_wstrb,
    output logic                  lsu_rsp_valid,
    input  logic                  lsu_rsp_ready,
    output logic [DATA_LEN-1:0]   lsu_rdata,
    output logic                  lsu_rsp_err,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_LEN-1:0]   mem_addr,
    output logic                  mem_wen,
    output logic [DATA_LEN-1:0]   mem_wdata,
    output logic [DATA_LEN/8-1:0] mem_wstrb,
    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [DATA_LEN-1:0]   mem_rdata,
    input  logic                  mem_rsp_err,

    output logic                  busy,
    output logic                  grant_id
);

    logic [1:0] state;
    logic       last_grant;
    logic       gnt_ifu;
    logic       gnt_lsu;
    logic       is_idle;
    logic       is_req;
    logic       is_rsp;
    logic       ifu_accept;
    logic       lsu_accept;
    logic       route_ifu;
    logic       route_lsu;
    logic       granted_rsp_ready;

    rr_arb2 u_rr_arb2 (
        .req0       (ifu_req_valid),
        .req1       (lsu_req_valid),
        .last_grant (last_grant),
        .gnt0       (gnt_ifu),
        .gnt1       (gnt_lsu)
    );

    assign is_idle = (state == IDLE);
    assign is_req  = (state == REQ);
    assign is_rsp  = (state == RSP);
    assign busy    = ~is_idle;

    assign ifu_req_ready = is_idle & gnt_ifu;
    assign lsu_req_ready = is_idle & gnt_lsu;
    assign ifu_accept    = ifu_req_valid & ifu_req_ready;
    assign lsu_accept    = lsu_req_valid & lsu_req_ready;

    assign mem_req_valid = is_req;

    // Responses reach only the granted master and only in RSP; strays elsewhere are dropped.
    assign route_ifu         = is_rsp & (grant_id == ID_IFU);
    assign route_lsu         = is_rsp & (grant_id == ID_LSU);
    assign granted_rsp_ready = (grant_id == ID_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
    assign mem_rsp_ready     = is_rsp & granted_rsp_ready;

    assign ifu_rsp_valid = route_ifu & mem_rsp_valid;
    assign ifu_rdata     = route_ifu ? mem_rdata : '0;
    assign ifu_rsp_err   = route_ifu & mem_rsp_err;
    assign lsu_rsp_valid = route_lsu & mem_rsp_valid;
    assign lsu_rdata     = route_lsu ? mem_rdata : '0;
    assign lsu_rsp_err   = route_lsu & mem_rsp_err;

    // Fetches are read-only, so an ifu grant latches a clean load with no strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= ID_IFU;
            grant_id   <= ID_IFU;
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_accept) begin
                        state      <= REQ;
                        last_grant <= ID_LSU;
                        grant_id   <= ID_LSU;
                        mem_addr   <= lsu_addr;
                        mem_wen    <= lsu_wen;
                        mem_wdata  <= lsu_wdata;
                        mem_wstrb  <= lsu_wstrb;
                    end else if (ifu_accept) begin
                        state      <= REQ;
                        last_grant <= ID_IFU;
                        grant_id   <= ID_IFU;
                        mem_addr   <= ifu_addr;
                        mem_wen    <= 1'b0;
                        mem_wdata  <= '0;
                        mem_wstrb  <= '0;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state <= RSP;
                    end
                end
                RSP: begin
                    if (mem_rsp_valid && mem_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions against a
// transaction-level round-robin model.
module tb_mem_arbiter;

    localparam int DL = 32;
    localparam int AL = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
    logic [AL-1:0] ifu_addr;
    logic [DL-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
    logic [AL-1:0] lsu_addr;
    logic [DL-1:0] lsu_wdata, lsu_rdata;
    logic [3:0]    lsu_wstrb;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
    logic [AL-1:0] mem_addr;
    logic [DL-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_wstrb;
    logic          busy, grant_id;

    int vectors = 0;
    int miscompares = 0;
    // Who won the previous transaction (0 = ifu, 1 = lsu); cleared by every reset.
    logic model_last = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_LEN(DL), .ADDR_LEN(AL)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
        .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
        .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
        .mem_rsp_err(mem_rsp_err),
        .busy(busy), .grant_id(grant_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 0; ifu_addr = '0; ifu_rsp_ready = 0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wstrb = '0;
        lsu_rsp_ready = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0; mem_rsp_err = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        model_last = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vectors++; if (grant_id !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_grant got %b want 0", grant_id); end
        vectors++; if ({mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid} !== 4'b0) begin
            miscompares++; $display("[TB] FAIL reset_valids got %b want 0000", {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}); end
        vectors++; if ({mem_addr, mem_wdata, mem_wstrb, mem_wen} !== '0) begin
            miscompares++; $display("[TB] FAIL reset_fields got %h/%h/%h/%b want 0", mem_addr, mem_wdata, mem_wstrb, mem_wen); end
        rst_n = 1;
        model_last = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        #1;
        vectors++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            miscompares++; $display("[TB] FAIL fetch_ready got %b want 10", {ifu_req_ready, lsu_req_ready}); end
        tick();
        ifu_req_valid = 0; mem_req_ready = 1;
        #1;
        vectors++; if ({mem_req_valid, mem_addr, mem_wen} !== {1'b1, 32'h8000_0000, 1'b0}) begin
            miscompares++; $display("[TB] FAIL fetch_req got v=%b a=%h w=%b want 1/80000000/0", mem_req_valid, mem_addr, mem_wen); end
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0000_0413; ifu_rsp_ready = 1;
        #1;
        vectors++; if ({ifu_rsp_valid, ifu_rdata, lsu_rsp_valid, mem_rsp_ready} !== {1'b1, 32'h0000_0413, 1'b0, 1'b1}) begin
            miscompares++; $display("[TB] FAIL fetch_rsp got v=%b d=%h lv=%b r=%b want 1/00000413/0/1", ifu_rsp_valid, ifu_rdata, lsu_rsp_valid, mem_rsp_ready); end
        tick();
        idle_inputs();
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_done busy got %b want 0", busy); end
        model_last = 1'b0;
    endtask

    task automatic test_store_stall();
        lsu_req_valid = 1; lsu_addr = 32'h8000_1004; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011; lsu_wen = 1;
        tick();
        lsu_req_valid = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wen = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if ({mem_req_valid, mem_addr, mem_wdata, mem_wstrb, mem_wen, grant_id} !==
                           {1'b1, 32'h8000_1004, 32'hDEAD_BEEF, 4'b0011, 1'b1, 1'b1}) begin
                miscompares++; $display("[TB] FAIL store_stall%0d got v=%b a=%h d=%h s=%b w=%b g=%b want 1/80001004/deadbeef/0011/1/1",
                                        i, mem_req_valid, mem_addr, mem_wdata, mem_wstrb, mem_wen, grant_id); end
            tick();
        end
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; lsu_rsp_ready = 1; mem_rdata = 32'h1234_5678;
        #1;
        vectors++; if ({lsu_rsp_valid, ifu_rsp_valid} !== 2'b10) begin
            miscompares++; $display("[TB] FAIL store_rsp got %b want 10", {lsu_rsp_valid, ifu_rsp_valid}); end
        tick();
        idle_inputs();
        model_last = 1'b1;
    endtask

    task automatic test_contention();
        logic exp_win;
        apply_reset();
        ifu_req_valid = 1; ifu_addr = 32'h0000_1000;
        lsu_req_valid = 1; lsu_addr = 32'h0000_2000;
        for (int t = 0; t < 4; t++) begin
            exp_win = ~model_last;
            #1;
            vectors++; if ({ifu_req_ready, lsu_req_ready} !== {~exp_win, exp_win}) begin
                miscompares++; $display("[TB] FAIL contend%0d_ready got %b want %b", t, {ifu_req_ready, lsu_req_ready}, {~exp_win, exp_win}); end
            tick();
            model_last = exp_win;
            vectors++; if ({grant_id, mem_addr} !== {exp_win, exp_win ? 32'h0000_2000 : 32'h0000_1000}) begin
                miscompares++; $display("[TB] FAIL contend%0d_grant got g=%b a=%h want g=%b", t, grant_id, mem_addr, exp_win); end
            mem_req_ready = 1;
            tick();
            mem_req_ready = 0; mem_rsp_valid = 1; ifu_rsp_ready = 1; lsu_rsp_ready = 1;
            #1;
            vectors++; if ({ifu_rsp_valid, lsu_rsp_valid} !== {~exp_win, exp_win}) begin
                miscompares++; $display("[TB] FAIL contend%0d_rsp got %b want %b", t, {ifu_rsp_valid, lsu_rsp_valid}, {~exp_win, exp_win}); end
            tick();
            mem_rsp_valid = 0;
        end
        idle_inputs();
    endtask

    task automatic test_rsp_backpressure();
        ifu_req_valid = 1; ifu_addr = 32'h0000_0040;
        tick();
        ifu_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'hCAFE_0001; ifu_rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if ({mem_rsp_ready, busy, ifu_rsp_valid} !== 3'b011) begin
                miscompares++; $display("[TB] FAIL bp_hold%0d got r/b/v=%b want 011", i, {mem_rsp_ready, busy, ifu_rsp_valid}); end
            tick();
        end
        ifu_rsp_ready = 1;
        #1;
        vectors++; if (mem_rsp_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_release got %b want 1", mem_rsp_ready); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_done busy got %b want 0", busy); end
        idle_inputs();
        model_last = 1'b0;
    endtask

    task automatic test_error();
        // A stray response while idle must not leak to either master.
        mem_rsp_valid = 1; mem_rsp_err = 1; ifu_rsp_ready = 1; lsu_rsp_ready = 1;
        #1;
        vectors++; if ({ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready, ifu_rsp_err, lsu_rsp_err} !== 5'b0) begin
            miscompares++; $display("[TB] FAIL stray_rsp got %b want 00000", {ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready, ifu_rsp_err, lsu_rsp_err}); end
        idle_inputs();
        lsu_req_valid = 1; lsu_addr = 32'h0000_0000; lsu_wen = 0;
        tick();
        lsu_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_err = 1; lsu_rsp_ready = 1;
        #1;
        vectors++; if ({lsu_rsp_valid, lsu_rsp_err, ifu_rsp_err} !== 3'b110) begin
            miscompares++; $display("[TB] FAIL err_route got %b want 110", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_err}); end
        tick();
        idle_inputs();
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL err_done busy got %b want 0", busy); end
        model_last = 1'b1;
    endtask

    task automatic test_reset_mid();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
        tick();
        ifu_req_valid = 0;
        vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_in_req got %b want 1", mem_req_valid); end
        rst_n = 0;
        #1;
        vectors++; if ({busy, mem_req_valid, mem_addr} !== {1'b0, 1'b0, 32'h0}) begin
            miscompares++; $display("[TB] FAIL rmid_clear got b=%b v=%b a=%h want 0/0/0", busy, mem_req_valid, mem_addr); end
        tick();
        rst_n = 1;
        model_last = 1'b0;
        ifu_req_valid = 1; lsu_req_valid = 1; lsu_addr = 32'h0000_0300;
        #1;
        vectors++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            miscompares++; $display("[TB] FAIL rmid_first_grant got %b want 01", {ifu_req_ready, lsu_req_ready}); end
        apply_reset();
    endtask

    task automatic test_random();
        int r, stalls;
        logic iv, lv, win, wen;
        logic [AL-1:0] ia, la, ea;
        logic [DL-1:0] wd, ewd, rd;
        logic [3:0] ws, ews;
        logic er, mready;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(1, 3); iv = r[0]; lv = r[1];
            ia = $urandom; la = $urandom; wd = $urandom; ws = 4'($urandom); wen = 1'($urandom);
            win = (iv && lv) ? ~model_last : lv;
            ea  = win ? la : ia;
            ewd = (win && wen) || win ? wd : '0;
            ews = win ? ws : '0;
            ifu_req_valid = iv; ifu_addr = ia;
            lsu_req_valid = lv; lsu_addr = la; lsu_wdata = wd; lsu_wstrb = ws; lsu_wen = wen;
            #1;
            vectors++; if ({ifu_req_ready, lsu_req_ready} !== {~win, win}) begin
                miscompares++; $display("[TB] FAIL rnd%0d_ready got %b want %b", t, {ifu_req_ready, lsu_req_ready}, {~win, win}); end
            tick();
            model_last = win;
            stalls = $urandom_range(0, 2);
            for (int s = 0; s <= stalls; s++) begin
                ifu_req_valid = 1'($urandom); lsu_req_valid = 1'($urandom);
                lsu_addr = $urandom; lsu_wdata = $urandom; ifu_addr = $urandom;
                mem_req_ready = (s == stalls);
                #1;
                vectors++; if ({mem_req_valid, busy, grant_id, mem_addr, mem_wen, mem_wdata, mem_wstrb, ifu_req_ready, lsu_req_ready} !==
                               {1'b1, 1'b1, win, ea, win & wen, ewd, ews, 1'b0, 1'b0}) begin
                    miscompares++; $display("[TB] FAIL rnd%0d_req got v=%b g=%b a=%h w=%b d=%h s=%b rdy=%b%b want g=%b a=%h w=%b d=%h s=%b",
                                            t, mem_req_valid, grant_id, mem_addr, mem_wen, mem_wdata, mem_wstrb,
                                            ifu_req_ready, lsu_req_ready, win, ea, win & wen, ewd, ews); end
                tick();
            end
            mem_req_ready = 0;
            ifu_req_valid = 0; lsu_req_valid = 0;
            stalls = $urandom_range(0, 2);
            for (int s = 0; s <= stalls; s++) begin
                rd = $urandom; er = 1'($urandom);
                mem_rdata = rd; mem_rsp_err = er;
                if (s == stalls) begin
                    mem_rsp_valid = 1; mready = 1;
                end else begin
                    mem_rsp_valid = 1'($urandom); mready = ~mem_rsp_valid;
                end
                ifu_rsp_ready = win ? 1'($urandom) : mready;
                lsu_rsp_ready = win ? mready : 1'($urandom);
                #1;
                vectors++; if ({mem_rsp_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid} !==
                               {mready, 1'b0, ~win & mem_rsp_valid, win & mem_rsp_valid}) begin
                    miscompares++; $display("[TB] FAIL rnd%0d_rsp_hs got %b want %b", t,
                                            {mem_rsp_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid},
                                            {mready, 1'b0, ~win & mem_rsp_valid, win & mem_rsp_valid}); end
                if (s == stalls) begin
                    vectors++; if ((win ? {lsu_rdata, lsu_rsp_err, ifu_rsp_err} : {ifu_rdata, ifu_rsp_err, lsu_rsp_err}) !== {rd, er, 1'b0}) begin
                        miscompares++; $display("[TB] FAIL rnd%0d_rsp_data got i=%h/%b l=%h/%b want %h/%b to %s",
                                                t, ifu_rdata, ifu_rsp_err, lsu_rdata, lsu_rsp_err, rd, er, win ? "lsu" : "ifu"); end
                end
                tick();
            end
            idle_inputs();
            #1;
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd%0d_done busy got %b want 0", t, busy); end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_store_stall();
        test_contention();
        test_rsp_backpressure();
        test_error();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
